control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/simplecpu_pkg.sv | 43 ++++
 rtl/control_unit_pc_reg.sv | 22 ++
 rtl/control_unit.sv | 179 +++++++++++++++++
 tb/tb_control_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplecpu_pkg.sv
// simplecpu_pkg: opcode and state encodings plus instruction-word field positions.
// The JMPZ states exist only when CTRL_JMPZ_EN is defined.
package simplecpu_pkg;

    typedef enum logic [3:0] {
        OP_LOAD  = 4'h0,
        OP_STORE = 4'h1,
        OP_ADD   = 4'h2,
        OP_LOADC = 4'h3,
        OP_SUB   = 4'h4,
        OP_JMPZ  = 4'h5,
        OP_LOADN = 4'h6
    } opcode_t;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_STORE,
        S_ADD,
        S_SUB,
        S_LOADC,
        S_LOADN,
`ifdef CTRL_JMPZ_EN
        S_JMPZ,
        S_JMPZ_JMP,
`endif
        S_HALT
    } state_t;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RA_MSB = 11;
    localparam int RA_LSB = 8;
    localparam int RB_MSB = 7;
    localparam int RB_LSB = 4;
    localparam int RC_MSB = 3;
    localparam int RC_LSB = 0;
    localparam int D_MSB  = 7;
    localparam int D_LSB  = 0;

endpackage

// File: rtl/control_unit_pc_reg.sv
// pc_reg: program counter with clear, increment and relative (offset) load.
module pc_reg #(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            inc_i,
    input  logic            ld_i,
    input  logic [PC_W-1:0] off_i,
    output logic [PC_W-1:0] pc_o
);
    logic [PC_W-1:0] pc_q, pc_d;

    always_comb pc_d = clr_i ? '0 : ld_i ? pc_q + off_i : inc_i ? pc_q + PC_W'(1) : pc_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pc_q <= '0;
        else        pc_q <= pc_d;

    assign pc_o = pc_q;
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/execute sequencer for the simple CPU datapath.
// Define CTRL_JMPZ_EN to enable the conditional relative jump (opcode 0101); otherwise it halts.
module control_unit
    import simplecpu_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int DM_AW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [PC_W-1:0]  I_addr,
    output logic             I_rd,
    input  logic [15:0]      I_data,
    output logic [DM_AW-1:0] D_addr,
    output logic             D_rd,
    output logic             D_wr,
    output logic             RF_s,
    output logic             RF_W_wr,
    output logic             RF_Rp_rd,
    output logic             RF_Rq_rd,
    output logic             alu_s0,
    output logic             RF_cons,
    output logic             RF_ext,
    output logic [3:0]       RF_W_addr,
    output logic [3:0]       RF_Rp_addr,
    output logic [3:0]       RF_Rq_addr,
    output logic [7:0]       Val_cons,
    input  logic             RF_Rp_zero,
    output logic             halted
);
    state_t          state_q, state_d;
    logic [15:0]     ir_q, ir_d;
    logic [3:0]      ra, rb, rc;
    logic [7:0]      d8;
    logic [PC_W-1:0] pc, pc_off;
    logic            pc_ld;

    assign ra = ir_q[RA_MSB:RA_LSB];
    assign rb = ir_q[RB_MSB:RB_LSB];
    assign rc = ir_q[RC_MSB:RC_LSB];
    assign d8 = ir_q[D_MSB:D_LSB];

    // PC already points past the JMPZ, hence the -1 to make the offset instruction-relative
    assign pc_off = {{(PC_W-8){d8[7]}}, d8} - PC_W'(1);

`ifdef CTRL_JMPZ_EN
    assign pc_ld = en && state_q == S_JMPZ_JMP;
`else
    logic unused_zero;
    assign unused_zero = RF_Rp_zero;
    assign pc_ld = 1'b0;
`endif

    pc_reg #(.PC_W(PC_W)) u_pc (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (en && state_q == S_INIT),
        .inc_i (en && state_q == S_FETCH),
        .ld_i  (pc_ld),
        .off_i (pc_off),
        .pc_o  (pc)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_INIT: begin
                state_d = S_FETCH;
                ir_d    = '0;
            end
            S_FETCH: begin
                state_d = S_DECODE;
                ir_d    = I_data;
            end
            S_DECODE:
                case (ir_q[OP_MSB:OP_LSB])
                    OP_LOAD:  state_d = S_LOAD;
                    OP_STORE: state_d = S_STORE;
                    OP_ADD:   state_d = S_ADD;
                    OP_LOADC: state_d = S_LOADC;
                    OP_SUB:   state_d = S_SUB;
`ifdef CTRL_JMPZ_EN
                    OP_JMPZ:  state_d = S_JMPZ;
`endif
                    OP_LOADN: state_d = S_LOADN;
                    default:  state_d = S_HALT;
                endcase
`ifdef CTRL_JMPZ_EN
            S_JMPZ:   state_d = RF_Rp_zero ? S_JMPZ_JMP : S_FETCH;
`endif
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
        if (!en) begin
            state_d = state_q;
            ir_d    = ir_q;
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= S_INIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end

    always_comb begin
        I_rd       = 1'b0;
        D_addr     = '0;
        D_rd       = 1'b0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_wr    = 1'b0;
        RF_Rp_rd   = 1'b0;
        RF_Rq_rd   = 1'b0;
        alu_s0     = 1'b0;
        RF_cons    = 1'b0;
        RF_ext     = 1'b0;
        RF_W_addr  = '0;
        RF_Rp_addr = '0;
        RF_Rq_addr = '0;
        Val_cons   = '0;
        case (state_q)
            S_FETCH: I_rd = 1'b1;
            S_LOAD: begin
                D_addr    = DM_AW'(d8);
                D_rd      = 1'b1;
                RF_s      = 1'b1;
                RF_W_addr = ra;
                RF_W_wr   = 1'b1;
            end
            S_STORE: begin
                D_addr     = DM_AW'(d8);
                D_wr       = 1'b1;
                RF_Rp_addr = ra;
                RF_Rp_rd   = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_W_addr  = ra;
                RF_W_wr    = 1'b1;
                RF_Rp_addr = rb;
                RF_Rp_rd   = 1'b1;
                RF_Rq_addr = rc;
                RF_Rq_rd   = 1'b1;
                alu_s0     = state_q == S_SUB;
            end
            S_LOADC, S_LOADN: begin
                RF_cons   = 1'b1;
                RF_ext    = state_q == S_LOADN;
                Val_cons  = d8;
                RF_W_addr = ra;
                RF_W_wr   = 1'b1;
            end
`ifdef CTRL_JMPZ_EN
            S_JMPZ: begin
                RF_Rp_addr = ra;
                RF_Rp_rd   = 1'b1;
            end
`endif
            default: ;
        endcase
        // a stall suppresses every strobe so nothing is written twice
        if (!en) begin
            I_rd     = 1'b0;
            D_rd     = 1'b0;
            D_wr     = 1'b0;
            RF_W_wr  = 1'b0;
            RF_Rp_rd = 1'b0;
            RF_Rq_rd = 1'b0;
        end
    end

    assign I_addr = pc;
    assign halted = state_q == S_HALT;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table vectors, multi-cycle corner sequences and a randomized program
// checked against an instruction-level model of the control unit.
module tb_control_unit;
    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, zero = 1'b0;
    logic [15:0] I_addr, I_data;
    logic [7:0]  D_addr, Val_cons;
    logic [3:0]  RF_W_addr, RF_Rp_addr, RF_Rq_addr;
    logic        I_rd, D_rd, D_wr, RF_s, RF_W_wr, RF_Rp_rd, RF_Rq_rd, alu_s0, RF_cons, RF_ext, halted;
    logic [15:0] im [256];

    assign I_data = im[I_addr[7:0]];

    control_unit #(.PC_W(16), .DM_AW(8)) dut (
        .clk(clk), .rst(rst), .en(en),
        .I_addr(I_addr), .I_rd(I_rd), .I_data(I_data),
        .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr),
        .RF_s(RF_s), .RF_W_wr(RF_W_wr), .RF_Rp_rd(RF_Rp_rd), .RF_Rq_rd(RF_Rq_rd),
        .alu_s0(alu_s0), .RF_cons(RF_cons), .RF_ext(RF_ext),
        .RF_W_addr(RF_W_addr), .RF_Rp_addr(RF_Rp_addr), .RF_Rq_addr(RF_Rq_addr),
        .Val_cons(Val_cons), .RF_Rp_zero(zero), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       i_rd, d_rd, d_wr, rf_s, w_wr, rp_rd, rq_rd, alu, cons, ext, halted;
        logic [3:0] wa, pa, qa;
        logic [7:0] da, vc;
        logic [15:0] ia;
    } ctl_t;

    typedef struct {
        logic [15:0] ins;
        ctl_t        exp;
    } vec_t;

    int n_chk = 0, n_fail = 0;

    function automatic ctl_t cur();
        ctl_t c;
        c.i_rd = I_rd; c.d_rd = D_rd; c.d_wr = D_wr; c.rf_s = RF_s; c.w_wr = RF_W_wr;
        c.rp_rd = RF_Rp_rd; c.rq_rd = RF_Rq_rd; c.alu = alu_s0; c.cons = RF_cons;
        c.ext = RF_ext; c.halted = halted; c.wa = RF_W_addr; c.pa = RF_Rp_addr;
        c.qa = RF_Rq_addr; c.da = D_addr; c.vc = Val_cons; c.ia = I_addr;
        return c;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Execute-cycle controls derived directly from the instruction's meaning
    function automatic ctl_t model_exec(input logic [15:0] ins);
        ctl_t c = '0;
        logic [3:0] op = ins[15:12];
        case (op)
            4'h0: begin c.d_rd = 1; c.rf_s = 1; c.w_wr = 1; c.wa = ins[11:8]; c.da = ins[7:0]; end
            4'h1: begin c.d_wr = 1; c.rp_rd = 1; c.pa = ins[11:8]; c.da = ins[7:0]; end
            4'h2, 4'h4: begin
                c.w_wr = 1; c.rp_rd = 1; c.rq_rd = 1; c.alu = (op == 4'h4);
                c.wa = ins[11:8]; c.pa = ins[7:4]; c.qa = ins[3:0];
            end
            4'h3, 4'h6: begin c.cons = 1; c.ext = (op == 4'h6); c.w_wr = 1; c.wa = ins[11:8]; c.vc = ins[7:0]; end
`ifdef CTRL_JMPZ_EN
            4'h5: begin c.rp_rd = 1; c.pa = ins[11:8]; end
`endif
            default: c.halted = 1;
        endcase
        return c;
    endfunction

    function automatic ctl_t fetch_ctl(input logic [15:0] ia);
        ctl_t c = '0;
        c.i_rd = 1; c.ia = ia;
        return c;
    endfunction

    function automatic ctl_t stalled(input ctl_t c0);
        ctl_t c = c0;
        c.i_rd = 0; c.d_rd = 0; c.d_wr = 0; c.w_wr = 0; c.rp_rd = 0; c.rq_rd = 0;
        return c;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0; en = 1; zero = 0;
        #1 chk("reset_state", cur(), 64'h0);
        @(negedge clk);
        rst = 1;
    endtask

    task automatic run_vec(input vec_t v);
        ctl_t after;
        im[0] = v.ins;
        im[1] = 16'h3000;
        do_reset();
        tick(1);
        chk("first_fetch", cur(), fetch_ctl(16'h0));
        tick(2);
        chk($sformatf("exec_%h", v.ins), cur(), v.exp);
        after = v.exp.halted ? v.exp : fetch_ctl(16'h1);
        tick(1);
        chk($sformatf("after_%h", v.ins), cur(), after);
    endtask

    localparam int P_INIT = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3, P_JMP = 4, P_HALT = 5;

    task automatic run_random(input int cycles);
        int phase = P_INIT;
        logic [15:0] nxt = 0, addr = 0, ins = 0;
        ctl_t e;
        bit reset_now;
        for (int i = 0; i < 256; i++) begin
            logic [3:0] op;
            int r = $urandom_range(0, 99);
`ifdef CTRL_JMPZ_EN
            op = (r < 3) ? 4'hF : 4'($urandom_range(0, 6));
`else
            op = (r < 3) ? 4'hF : 4'($urandom_range(0, 5));
            if (op == 4'h5) op = 4'h6;
`endif
            im[i] = {op, 12'($urandom_range(0, 4095))};
        end
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            en = $urandom_range(0, 4) != 0;
            zero = 1'($urandom_range(0, 1));
            #1;
            e = '0;
            case (phase)
                P_FETCH: e = fetch_ctl(nxt);
                P_EXEC:  begin e = model_exec(ins); e.ia = addr + 16'd1; end
                P_HALT:  begin e.halted = 1; e.ia = addr + 16'd1; end
                P_INIT:  e.ia = 16'h0;
                default: e.ia = addr + 16'd1;
            endcase
            if (!en) e = stalled(e);
            chk($sformatf("rand_c%0d", c), cur(), e);
            reset_now = 0;
            if (en) begin
                case (phase)
                    P_INIT:  begin phase = P_FETCH; nxt = 0; end
                    P_FETCH: begin addr = nxt; ins = im[addr[7:0]]; nxt = addr + 16'd1; phase = P_DEC; end
                    P_DEC:   phase = model_exec(ins).halted ? P_HALT : P_EXEC;
                    P_EXEC:  begin
                        phase = P_FETCH;
                        if (ins[15:12] == 4'h5 && zero) begin
                            phase = P_JMP;
                            nxt = addr + {{8{ins[7]}}, ins[7:0]};
                        end
                    end
                    P_JMP:   phase = P_FETCH;
                    default: reset_now = $urandom_range(0, 3) == 0;
                endcase
            end
            if (reset_now) begin
                do_reset();
                phase = P_INIT;
            end else
                @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        ctl_t e;
        for (int i = 0; i < 256; i++) im[i] = 16'h0;
        tbl.push_back('{16'h3105, {11'b00001000100, 4'h1, 4'h0, 4'h0, 8'h00, 8'h05, 16'h0001}});
        tbl.push_back('{16'h2212, {11'b00001110000, 4'h2, 4'h1, 4'h2, 8'h00, 8'h00, 16'h0001}});
        tbl.push_back('{16'h4212, {11'b00001111000, 4'h2, 4'h1, 4'h2, 8'h00, 8'h00, 16'h0001}});
        tbl.push_back('{16'h0A10, {11'b01011000000, 4'hA, 4'h0, 4'h0, 8'h10, 8'h00, 16'h0001}});
        tbl.push_back('{16'h1A20, {11'b00100100000, 4'h0, 4'hA, 4'h0, 8'h20, 8'h00, 16'h0001}});
        tbl.push_back('{16'h63F9, {11'b00001000110, 4'h3, 4'h0, 4'h0, 8'h00, 8'hF9, 16'h0001}});
        tbl.push_back('{16'hF000, {11'b00000000001, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 16'h0001}});
        tbl.push_back('{16'h7123, {11'b00000000001, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 16'h0001}});
`ifdef CTRL_JMPZ_EN
        tbl.push_back('{16'h53FE, {11'b00000100000, 4'h0, 4'h3, 4'h0, 8'h00, 8'h00, 16'h0001}});
`else
        tbl.push_back('{16'h53FE, {11'b00000000001, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 16'h0001}});
`endif
        foreach (tbl[i]) run_vec(tbl[i]);

        // ADD stalled for 5 cycles in its execute state, then exactly one write
        im[0] = 16'h2212;
        do_reset();
        tick(3);
        e = model_exec(16'h2212);
        e.ia = 16'h1;
        @(negedge clk);
        en = 0;
        for (int k = 0; k < 5; k++) begin
            #1 chk($sformatf("stall_%0d", k), cur(), stalled(e));
            @(negedge clk);
        end
        en = 1;
        #1 chk("stall_release", cur(), e);
        tick(1);
        chk("stall_after", cur(), fetch_ctl(16'h1));

        // reset in the middle of an execute cycle drops the write at once
        do_reset();
        tick(3);
        #2 rst = 0;
        #1 chk("abort_reset", cur(), 64'h0);
        @(negedge clk);
        rst = 1;

        // HALT is absorbing; a reset pulse restarts from address 0
        im[0] = 16'hF000;
        do_reset();
        tick(3);
        e = '0; e.halted = 1; e.ia = 16'h1;
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("halt_%0d", k), cur(), e);
            tick(1);
        end
        @(negedge clk);
        rst = 0;
        #1 chk("halt_reset", cur(), 64'h0);
        @(negedge clk);
        rst = 1;
        tick(1);
        chk("halt_refetch", cur(), fetch_ctl(16'h0));

        // JMPZ r3,-2 at address 4, taken and not taken
        for (int z = 0; z < 2; z++) begin
            for (int k = 0; k < 4; k++) im[k] = 16'h3000 | 16'(k);
            im[4] = 16'h53FE;
            do_reset();
            tick(13);
            chk($sformatf("jmpz%0d_fetch", z), cur(), fetch_ctl(16'h4));
            @(negedge clk);
            zero = 1'(z);
            tick(2);
            e = model_exec(16'h53FE);
            e.ia = 16'h5;
            chk($sformatf("jmpz%0d_exec", z), cur(), e);
`ifdef CTRL_JMPZ_EN
            tick(1);
            if (z == 1) begin
                e = '0; e.ia = 16'h5;
                chk("jmpz1_jmp", cur(), e);
                tick(1);
                chk("jmpz1_target", cur(), fetch_ctl(16'h2));
            end else
                chk("jmpz0_target", cur(), fetch_ctl(16'h5));
`else
            tick(1);
            chk($sformatf("jmpz%0d_halt", z), cur(), e);
`endif
        end

        run_random(1500);
        en = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
